// File: rtl/mul_share_ctrl_if.sv
// Requester-side channel of the shared multiplier: request handshake plus result return.
interface mul_share_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [1:0]      op;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    modport master (
        output valid, rs1, rs2, op, resp_ready,
        input  ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  valid, rs1, rs2, op, resp_ready,
        output ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one iterative multiplier between two requesters, with
// RV32M high/low and signedness decode and a completion timeout.
module mul_share_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    mul_share_ctrl_if.slave   req0,
    mul_share_ctrl_if.slave   req1,
    output logic [XLEN-1:0]   mul_rs1,
    output logic [XLEN-1:0]   mul_rs2,
    output logic              mul_rs1_signed,
    output logic              mul_rs2_signed,
    output logic              mul_start,
    input  logic [2*XLEN-1:0] mul_result,
    input  logic              mul_valid,
    input  logic              mul_busy
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic                 hi_q, hi_d;
    logic [XLEN-1:0]      rs1_q, rs1_d;
    logic [XLEN-1:0]      rs2_q, rs2_d;
    logic                 rs1_signed_q, rs1_signed_d;
    logic                 rs2_signed_q, rs2_signed_d;
    logic                 start_q, start_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [1:0]           resp_valid_q, resp_valid_d;
    logic [1:0]           resp_err_q, resp_err_d;
    logic [1:0][XLEN-1:0] resp_data_q, resp_data_d;

    logic            grant_c;
    logic            accept_c;
    logic            timeout_c;
    logic [XLEN-1:0] sel_rs1_c;
    logic [XLEN-1:0] sel_rs2_c;
    logic [1:0]      sel_op_c;
    logic [1:0]      resp_ready_c;

    // A lone requester wins; on a tie the one not served last time wins.
    always_comb begin
        grant_c = ~last_grant_q;
        if (req0.valid && !req1.valid) begin
            grant_c = 1'b0;
        end else if (req1.valid && !req0.valid) begin
            grant_c = 1'b1;
        end
    end

    assign accept_c     = (state_q == S_IDLE) && (grant_c ? req1.valid : req0.valid);
    assign sel_rs1_c    = grant_c ? req1.rs1 : req0.rs1;
    assign sel_rs2_c    = grant_c ? req1.rs2 : req0.rs2;
    assign sel_op_c     = grant_c ? req1.op : req0.op;
    assign resp_ready_c = {req1.resp_ready, req0.resp_ready};
    assign timeout_c    = (timer_q >= TW'(TIMEOUT_CYC - 1));

    // Sequencer: accept, launch, wait for busy, wait for done/timeout, respond.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        hi_d         = hi_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs1_signed_d = rs1_signed_q;
        rs2_signed_d = rs2_signed_q;
        start_d      = 1'b0;
        timer_d      = timer_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    rs1_d        = sel_rs1_c;
                    rs2_d        = sel_rs2_c;
                    rs1_signed_d = (sel_op_c == OP_MULH) || (sel_op_c == OP_MULHSU);
                    rs2_signed_d = (sel_op_c == OP_MULH);
                    hi_d         = (sel_op_c != OP_MUL);
                    start_d      = 1'b1;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                timer_d = timer_q + TW'(1);
                if (timeout_c) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_err_d[owner_q]   = 1'b1;
                    resp_data_d[owner_q]  = '0;
                    state_d               = S_RESP;
                end else if (mul_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_q + TW'(1);
                if (mul_valid && !mul_busy) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_err_d[owner_q]   = 1'b0;
                    resp_data_d[owner_q]  = hi_q ? mul_result[2*XLEN-1:XLEN]
                                                 : mul_result[XLEN-1:0];
                    state_d               = S_RESP;
                end else if (timeout_c) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_err_d[owner_q]   = 1'b1;
                    resp_data_d[owner_q]  = '0;
                    state_d               = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_c[owner_q]) begin
                    resp_valid_d[owner_q] = 1'b0;
                    state_d               = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            hi_q         <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_signed_q <= 1'b0;
            rs2_signed_q <= 1'b0;
            start_q      <= 1'b0;
            timer_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            hi_q         <= hi_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs1_signed_q <= rs1_signed_d;
            rs2_signed_q <= rs2_signed_d;
            start_q      <= start_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Ready is held low during reset so every output reads 0 there.
    assign req0.ready = !rst && (state_q == S_IDLE) && !grant_c;
    assign req1.ready = !rst && (state_q == S_IDLE) && grant_c;

    assign req0.resp_valid = resp_valid_q[0];
    assign req0.resp_err   = resp_err_q[0];
    assign req0.resp_data  = resp_data_q[0];
    assign req1.resp_valid = resp_valid_q[1];
    assign req1.resp_err   = resp_err_q[1];
    assign req1.resp_data  = resp_data_q[1];

    assign mul_rs1        = rs1_q;
    assign mul_rs2        = rs2_q;
    assign mul_rs1_signed = rs1_signed_q;
    assign mul_rs2_signed = rs2_signed_q;
    assign mul_start      = start_q;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: stub multiplier, directed corner cases, random traffic.
`timescale 1ns/1ps
module tb_mul_share_ctrl;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_HANG   = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid   [2];
    logic [31:0] req_rs1     [2];
    logic [31:0] req_rs2     [2];
    logic [1:0]  req_op      [2];
    logic        resp_ready  [2];
    logic        req_ready_w [2];
    logic        resp_valid_w[2];
    logic        resp_err_w  [2];
    logic [31:0] resp_data_w [2];

    logic [31:0] mul_rs1, mul_rs2;
    logic        mul_rs1_signed, mul_rs2_signed, mul_start;
    logic [63:0] mul_result;
    logic        mul_valid, mul_busy;

    mul_share_ctrl_if #(.XLEN(XLEN)) r0 ();
    mul_share_ctrl_if #(.XLEN(XLEN)) r1 ();

    assign r0.valid      = req_valid[0];
    assign r0.rs1        = req_rs1[0];
    assign r0.rs2        = req_rs2[0];
    assign r0.op         = req_op[0];
    assign r0.resp_ready = resp_ready[0];
    assign r1.valid      = req_valid[1];
    assign r1.rs1        = req_rs1[1];
    assign r1.rs2        = req_rs2[1];
    assign r1.op         = req_op[1];
    assign r1.resp_ready = resp_ready[1];
    assign req_ready_w[0]  = r0.ready;
    assign req_ready_w[1]  = r1.ready;
    assign resp_valid_w[0] = r0.resp_valid;
    assign resp_valid_w[1] = r1.resp_valid;
    assign resp_err_w[0]   = r0.resp_err;
    assign resp_err_w[1]   = r1.resp_err;
    assign resp_data_w[0]  = r0.resp_data;
    assign resp_data_w[1]  = r1.resp_data;

    mul_share_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (r0.slave),
        .req1           (r1.slave),
        .mul_rs1        (mul_rs1),
        .mul_rs2        (mul_rs2),
        .mul_rs1_signed (mul_rs1_signed),
        .mul_rs2_signed (mul_rs2_signed),
        .mul_start      (mul_start),
        .mul_result     (mul_result),
        .mul_valid      (mul_valid),
        .mul_busy       (mul_busy)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          mul_mode = MODE_NORMAL;
    bit          rr_force[2];
    bit          rr_val[2];
    logic [32:0] sbq0[$];
    logic [32:0] sbq1[$];
    int          accept_log[$];
    logic [31:0] last_data[2];
    logic        last_err[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M result straight from the instruction definition.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        longint sa, sb;
        logic [63:0] p;
        sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'h0, a});
        sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'h0, b});
        p  = 64'(sa * sb);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                  input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Stub multiplier: samples operands only when it finishes, so unstable operands show up.
    initial begin
        int d, n;
        mul_busy   = 1'b0;
        mul_valid  = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk); #2;
            mul_valid = 1'b0;
            if (!rst && mul_start) begin
                if (mul_mode == MODE_HANG) begin
                    mul_busy = 1'b1;
                    for (int i = 0; i < 400; i++) begin
                        @(posedge clk); #2;
                        if (rst || resp_valid_w[0] || resp_valid_w[1]) break;
                    end
                    mul_busy = 1'b0;
                end else begin
                    d = $urandom_range(0, 3);
                    n = $urandom_range(2, 6);
                    repeat (d) begin @(posedge clk); #2; end
                    mul_busy = 1'b1;
                    repeat (n) begin @(posedge clk); #2; end
                    mul_busy   = 1'b0;
                    mul_valid  = 1'b1;
                    mul_result = model_product(mul_rs1, mul_rs2, mul_rs1_signed, mul_rs2_signed);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++)
            resp_ready[p] = rr_force[p] ? rr_val[p] : ($urandom_range(0, 3) != 0);
    end

    // Monitor: arbitration model, expectation push on accept, pop/compare on response.
    bit          model_last = 1'b1;
    bit          expect_start = 1'b0;
    bit          prev_start = 1'b0;
    bit          hold_on = 1'b0;
    bit          hold_bad = 1'b0;
    logic [33:0] hold_ops;
    always @(negedge clk) begin
        if (rst) begin
            sbq0.delete();
            sbq1.delete();
            model_last   = 1'b1;
            expect_start = 1'b0;
            prev_start   = 1'b0;
            hold_on      = 1'b0;
        end else begin
            if (expect_start) begin
                check("start_latency", 64'(mul_start), 64'd1);
                expect_start = 1'b0;
            end
            if (mul_start && prev_start) check("start_width", 64'd2, 64'd1);
            prev_start = mul_start;
            if (mul_start) begin
                hold_ops = {mul_rs1_signed, mul_rs2_signed, mul_rs1 ^ mul_rs2};
                hold_on  = 1'b1;
                hold_bad = 1'b0;
            end else if (hold_on) begin
                if ({mul_rs1_signed, mul_rs2_signed, mul_rs1 ^ mul_rs2} !== hold_ops) hold_bad = 1'b1;
                if (mul_valid && !mul_busy) begin
                    check("operand_hold", 64'(hold_bad), 64'd0);
                    hold_on = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                logic        eg;
                logic [32:0] e;
                if (req_valid[p] && req_ready_w[p]) begin
                    eg = (req_valid[0] && req_valid[1]) ? !model_last : req_valid[1];
                    check("grant", 64'(p), 64'(eg));
                    model_last = p[0];
                    e = (mul_mode == MODE_HANG) ? {1'b1, 32'h0}
                                                : {1'b0, ref_mul(req_rs1[p], req_rs2[p], req_op[p])};
                    if (p == 0) sbq0.push_back(e); else sbq1.push_back(e);
                    accept_log.push_back(p);
                    expect_start = 1'b1;
                end
            end
            if (resp_valid_w[0] || resp_valid_w[1])
                check("resp_exclusive", 64'(resp_valid_w[0] && resp_valid_w[1]), 64'd0);
            for (int p = 0; p < 2; p++) begin
                logic [32:0] e;
                if (resp_valid_w[p] && resp_ready[p]) begin
                    if ((p == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                        check("resp_unexpected", 64'(p), 64'd9);
                    end else begin
                        e = (p == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        check("resp_data", 64'(resp_data_w[p]), 64'(e[31:0]));
                        check("resp_err", 64'(resp_err_w[p]), 64'(e[32]));
                    end
                    last_data[p] = resp_data_w[p];
                    last_err[p]  = resp_err_w[p];
                end
            end
        end
    end

    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input int max_wait, output bit acc);
        acc = 1'b0;
        @(posedge clk); #1;
        req_valid[p] = 1'b1;
        req_rs1[p]   = a;
        req_rs2[p]   = b;
        req_op[p]    = op;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (req_ready_w[p]) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        req_rs1[p]   = $urandom();
        req_rs2[p]   = $urandom();
        req_op[p]    = 2'($urandom_range(0, 3));
    endtask

    task automatic send_must(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op);
        bit acc;
        send(p, a, b, op, 2000, acc);
        check("accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sbq0.size() == 0 && sbq1.size() == 0 && !resp_valid_w[0] && !resp_valid_w[1]
                && !req_valid[0] && !req_valid[1]) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", 64'(done), 64'd1);
    endtask

    task automatic rst_pulse();
        @(negedge clk); #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic rand_traffic(input int p);
        bit acc;
        logic [31:0] a, b;
        logic [1:0]  op;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            a  = pick();
            b  = pick();
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) send(p, a, b, op, $urandom_range(1, 3), acc);
            else send_must(p, a, b, op);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mul_start"}, 64'(mul_start), 64'd0);
        check({tag, "_mul_ops"}, {mul_rs1, mul_rs2}, 64'd0);
        check({tag, "_mul_signed"}, 64'({mul_rs1_signed, mul_rs2_signed}), 64'd0);
        check({tag, "_ready"}, 64'({req_ready_w[0], req_ready_w[1]}), 64'd0);
        check({tag, "_resp_valid"}, 64'({resp_valid_w[0], resp_valid_w[1]}), 64'd0);
        check({tag, "_resp_err"}, 64'({resp_err_w[0], resp_err_w[1]}), 64'd0);
        check({tag, "_resp_data"}, {resp_data_w[0], resp_data_w[1]}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_rs1[p]   = '0;
            req_rs2[p]   = '0;
            req_op[p]    = '0;
            rr_force[p]  = 1'b0;
            rr_val[p]    = 1'b0;
            last_data[p] = '0;
            last_err[p]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;

        send_must(0, 32'd7, 32'd6, 2'b00);
        drain();
        check("mul_7x6", 64'(last_data[0]), 64'h2A);
        check("mul_7x6_err", 64'(last_err[0]), 64'd0);

        send_must(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        drain();
        check("mulh_m1", 64'(last_data[1]), 64'h0);
        send_must(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        drain();
        check("mul_m1", 64'(last_data[1]), 64'h1);

        send_must(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
        drain();
        check("mulhu_max", 64'(last_data[0]), 64'hFFFF_FFFE);
        send_must(0, 32'hFFFF_FFFE, 32'd3, 2'b10);
        drain();
        check("mulhsu_m2x3", 64'(last_data[0]), 64'hFFFF_FFFF);

        // Round robin after reset with both requesters always pending.
        rst_pulse();
        accept_log.delete();
        fork
            begin
                send_must(0, 32'd11, 32'd3, 2'b00);
                send_must(0, 32'd12, 32'd3, 2'b00);
            end
            begin
                send_must(1, 32'd13, 32'd3, 2'b00);
                send_must(1, 32'd14, 32'd3, 2'b00);
            end
        join
        drain();
        check("rr_count", 64'(accept_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < accept_log.size(); i++)
            check("rr_order", 64'(accept_log[i]), 64'(i % 2));

        // Requester 0 stalls its response; requester 1 must wait.
        rr_force[0] = 1'b1;
        rr_val[0]   = 1'b0;
        fork
            send_must(0, 32'h1234_5678, 32'hFEDC_BA98, 2'b01);
            begin
                repeat (2) @(posedge clk);
                send_must(1, 32'd100, 32'd200, 2'b00);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (resp_valid_w[0]) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stall_resp_seen", 64'(seen), 64'd1);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_valid", 64'(resp_valid_w[0]), 64'd1);
                    check("stall_data", 64'(resp_data_w[0]),
                          64'(ref_mul(32'h1234_5678, 32'hFEDC_BA98, 2'b01)));
                    check("stall_other_ready", 64'({req_valid[1], req_ready_w[1]}), 64'b10);
                end
                rr_force[0] = 1'b0;
            end
        join
        drain();

        // Multiplier never completes: timeout response.
        mul_mode = MODE_HANG;
        fork
            send_must(1, 32'd5, 32'd9, 2'b00);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (mul_start) begin
                        seen = 1'b1;
                        break;
                    end
                end
                cnt = 0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    cnt++;
                    if (resp_valid_w[1]) break;
                end
                check("timeout_start_seen", 64'(seen), 64'd1);
                check("timeout_latency_ok",
                      64'(cnt >= TIMEOUT_CYC && cnt <= TIMEOUT_CYC + 2), 64'd1);
            end
        join
        drain();
        check("timeout_err", 64'(last_err[1]), 64'd1);
        check("timeout_data", 64'(last_data[1]), 64'd0);

        // Reset while the multiplier is computing.
        fork
            send_must(0, 32'd77, 32'd88, 2'b11);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (mul_start) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("midrst_start_seen", 64'(seen), 64'd1);
            end
        join
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        #2 rst = 1'b0;
        mul_mode = MODE_NORMAL;
        send_must(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11);
        drain();
        check("after_rst_data", 64'(last_data[0]),
              64'(ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 2'b11)));
        check("after_rst_err", 64'(last_err[0]), 64'd0);

        fork
            rand_traffic(0);
            rand_traffic(1);
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
